transform_quant_pipe: RTL

Streaming successor to the single-block transform coder. Accepts one 4x4 residual block per handshake with its own QP and intra/inter flag, and applies the H.264 4x4 forward integer core transform. It then quantizes each coefficient with the standard MF/qbits scheme and emits the 16 levels through a 3-stage stall-able pipeline. It sits between the residual generator and the entropy coder.

---
 rtl/transform_quant_pipe.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/transform_quant_pipe.sv
// 3-stage stall-able 4x4 forward integer transform + MF/qbits quantizer.
// Optional TQ_NZ_COUNT_EN adds out_nz_count (nonzero levels in out_level).
module transform_quant_pipe #(
  parameter int unsigned IN_WIDTH  = 9,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned QP_WIDTH  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [16*IN_WIDTH-1:0]    in_res,
  input  logic [QP_WIDTH-1:0]       in_qp,
  input  logic                      in_intra,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [16*OUT_WIDTH-1:0]   out_level
`ifdef TQ_NZ_COUNT_EN
  ,
  output logic [4:0]                out_nz_count
`endif
);

  localparam int unsigned YWidth = IN_WIDTH + 3;
  localparam int unsigned WWidth = IN_WIDTH + 6;
  localparam int unsigned PWidth = WWidth + 14;
  localparam logic [OUT_WIDTH-1:0] MaxPos = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MinNeg = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // {QP/6, QP%6} for QP in 0..51; loop indices are constants, so this folds to a table.
  function automatic logic [6:0] f_qp_lut(input logic [5:0] q);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 52; i++) begin
      if (q == 6'(i)) r = {4'(i / 6), 3'(i % 6)};
    end
    return r;
  endfunction

  function automatic logic [13:0] f_mf(input logic [2:0] m, input logic r_odd, input logic c_odd);
    logic [1:0] cls;
    logic [13:0] mf;
    cls = (!r_odd && !c_odd) ? 2'd0 : ((r_odd && c_odd) ? 2'd1 : 2'd2);
    case (m)
      3'd0:    mf = (cls == 2'd0) ? 14'd13107 : ((cls == 2'd1) ? 14'd5243 : 14'd8066);
      3'd1:    mf = (cls == 2'd0) ? 14'd11916 : ((cls == 2'd1) ? 14'd4660 : 14'd7490);
      3'd2:    mf = (cls == 2'd0) ? 14'd10082 : ((cls == 2'd1) ? 14'd4194 : 14'd6554);
      3'd3:    mf = (cls == 2'd0) ? 14'd9362  : ((cls == 2'd1) ? 14'd3647 : 14'd5825);
      3'd4:    mf = (cls == 2'd0) ? 14'd8192  : ((cls == 2'd1) ? 14'd3355 : 14'd5243);
      default: mf = (cls == 2'd0) ? 14'd7282  : ((cls == 2'd1) ? 14'd2893 : 14'd4559);
    endcase
    return mf;
  endfunction

  // floor(2^e / 3); inter rounding uses e-1 since 2^q/6 == 2^(q-1)/3.
  function automatic logic [21:0] f_third(input logic [4:0] e);
    case (e)
      5'd14:   return 22'd5461;
      5'd15:   return 22'd10922;
      5'd16:   return 22'd21845;
      5'd17:   return 22'd43690;
      5'd18:   return 22'd87381;
      5'd19:   return 22'd174762;
      5'd20:   return 22'd349525;
      5'd21:   return 22'd699050;
      5'd22:   return 22'd1398101;
      default: return 22'd2796202;
    endcase
  endfunction

  logic w_adv;
  assign w_adv    = enable & (~out_valid | out_ready);
  assign in_ready = w_adv & reset;

  // Stage 1: row transform
  logic signed [YWidth-1:0] w_x [16];
  logic signed [YWidth-1:0] w_y [16];
  logic        [5:0]        w_qp_cl;
  always_comb begin
    for (int k = 0; k < 16; k++) w_x[k] = YWidth'($signed(in_res[k*IN_WIDTH +: IN_WIDTH]));
    for (int r = 0; r < 4; r++) begin
      w_y[4*r]   = w_x[4*r] + w_x[4*r+1] + w_x[4*r+2] + w_x[4*r+3];
      w_y[4*r+1] = (w_x[4*r] <<< 1) + w_x[4*r+1] - w_x[4*r+2] - (w_x[4*r+3] <<< 1);
      w_y[4*r+2] = w_x[4*r] - w_x[4*r+1] - w_x[4*r+2] + w_x[4*r+3];
      w_y[4*r+3] = w_x[4*r] - (w_x[4*r+1] <<< 1) + (w_x[4*r+2] <<< 1) - w_x[4*r+3];
    end
    w_qp_cl = (in_qp > QP_WIDTH'(51)) ? 6'd51 : 6'(in_qp);
  end

  // Stage 2: column transform and QP decomposition
  logic signed [YWidth-1:0] r_s1_y [16];
  logic        [5:0]        r_s1_qp;
  logic                     r_s1_intra, r_s1_valid;
  logic signed [WWidth-1:0] w_ye [16];
  logic signed [WWidth-1:0] w_w  [16];
  logic        [6:0]        w_qp_dm;
  always_comb begin
    for (int k = 0; k < 16; k++) w_ye[k] = WWidth'(r_s1_y[k]);
    for (int c = 0; c < 4; c++) begin
      w_w[c]    = w_ye[c] + w_ye[4+c] + w_ye[8+c] + w_ye[12+c];
      w_w[4+c]  = (w_ye[c] <<< 1) + w_ye[4+c] - w_ye[8+c] - (w_ye[12+c] <<< 1);
      w_w[8+c]  = w_ye[c] - w_ye[4+c] - w_ye[8+c] + w_ye[12+c];
      w_w[12+c] = w_ye[c] - (w_ye[4+c] <<< 1) + (w_ye[8+c] <<< 1) - w_ye[12+c];
    end
    w_qp_dm = f_qp_lut(r_s1_qp);
  end

  // Stage 3: quantization with saturation
  logic signed [WWidth-1:0]    r_s2_w [16];
  logic        [3:0]           r_s2_qdiv;
  logic        [2:0]           r_s2_qmod;
  logic                        r_s2_intra, r_s2_valid;
  logic        [4:0]           w_qbits;
  logic        [21:0]          w_f;
  logic                        w_neg [16];
  logic        [WWidth-1:0]    w_abs [16];
  logic        [PWidth-1:0]    w_mag [16];
  logic        [OUT_WIDTH-1:0] w_lvl [16];
  always_comb begin
    w_qbits = 5'd15 + 5'(r_s2_qdiv);
    w_f     = r_s2_intra ? f_third(w_qbits) : f_third(w_qbits - 5'd1);
    for (int k = 0; k < 16; k++) begin
      w_neg[k] = r_s2_w[k][WWidth-1];
      w_abs[k] = w_neg[k] ? -r_s2_w[k] : r_s2_w[k];
      w_mag[k] = (PWidth'(w_abs[k]) * PWidth'(f_mf(r_s2_qmod, 1'(k >> 2), 1'(k)))
                  + PWidth'(w_f)) >> w_qbits;
      if (!w_neg[k]) w_lvl[k] = (w_mag[k] > PWidth'(MaxPos)) ? MaxPos : w_mag[k][OUT_WIDTH-1:0];
      else w_lvl[k] = (w_mag[k] > PWidth'(MinNeg)) ? MinNeg : -w_mag[k][OUT_WIDTH-1:0];
    end
  end

`ifdef TQ_NZ_COUNT_EN
  logic [4:0] w_nz, r_nz;
  always_comb begin
    w_nz = '0;
    for (int k = 0; k < 16; k++) if (w_lvl[k] != '0) w_nz = w_nz + 5'd1;
  end
  assign out_nz_count = r_nz;
`endif

  logic                       r_out_valid;
  logic [16*OUT_WIDTH-1:0]    r_out_level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_qp     <= '0;
      r_s1_intra  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_qdiv   <= '0;
      r_s2_qmod   <= '0;
      r_s2_intra  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_level <= '0;
      for (int k = 0; k < 16; k++) begin
        r_s1_y[k] <= '0;
        r_s2_w[k] <= '0;
      end
`ifdef TQ_NZ_COUNT_EN
      r_nz        <= '0;
`endif
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_s1_qp     <= w_qp_cl;
      r_s1_intra  <= in_intra;
      r_s2_valid  <= r_s1_valid;
      r_s2_qdiv   <= w_qp_dm[6:3];
      r_s2_qmod   <= w_qp_dm[2:0];
      r_s2_intra  <= r_s1_intra;
      r_out_valid <= r_s2_valid;
      for (int k = 0; k < 16; k++) begin
        r_s1_y[k] <= w_y[k];
        r_s2_w[k] <= w_w[k];
        r_out_level[k*OUT_WIDTH +: OUT_WIDTH] <= w_lvl[k];
      end
`ifdef TQ_NZ_COUNT_EN
      r_nz        <= w_nz;
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign out_level = r_out_level;

endmodule
